// File: rtl/verifier_beta_sequencer_if.sv
// verifier_beta_sequencer_if: request/response bus between the beta sequencer and one beta element
`ifndef F_NBITS
`define F_NBITS 61
`endif
interface verifier_beta_sequencer_if;
  logic elem_en, elem_restart, elem_mul_beta, elem_ready;
  logic [`F_NBITS-1:0] elem_w_val, elem_z_val, elem_beta;
  logic [1:0][`F_NBITS-1:0] elem_mul_beta_in;
  modport master(
    output elem_en, elem_restart, elem_mul_beta, elem_w_val, elem_z_val, elem_mul_beta_in,
    input  elem_ready, elem_beta
  );
  modport slave(
    input  elem_en, elem_restart, elem_mul_beta, elem_w_val, elem_z_val, elem_mul_beta_in,
    output elem_ready, elem_beta
  );
endinterface

// File: rtl/verifier_beta_sequencer.sv
// verifier_beta_sequencer: walks NVALS (w,z) pairs through one beta element, then optionally scales the product
`ifndef F_NBITS
`define F_NBITS 61
`endif
module verifier_beta_sequencer #(
  parameter int NVALS = 8
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             en,
  input  logic [NVALS-1:0][`F_NBITS-1:0]   w_vals,
  input  logic [NVALS-1:0][`F_NBITS-1:0]   z_vals,
  input  logic                             scale_en,
  input  logic [`F_NBITS-1:0]              scale_val,
  verifier_beta_sequencer_if.master        elem,
  output logic                             ready,
  output logic                             done,
  output logic [`F_NBITS-1:0]              beta_out
);
  localparam int FW = `F_NBITS;
  localparam int IW = NVALS > 1 ? $clog2(NVALS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NVALS - 1);
  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_GAP, ST_WAIT,
    ST_SCALE_ISSUE, ST_SCALE_GAP, ST_SCALE_WAIT, ST_DONE
  } state_t;
  state_t state, state_nx;
  logic en_dly, scale_en_q, scale_nx, start;
  logic [IW-1:0] idx, idx_nx;
  logic [FW-1:0] beta_nx;
  assign start = en & ~en_dly;
  assign ready = (state == ST_IDLE) & ~start;
  assign done = state == ST_DONE;
  assign elem.elem_en = (state == ST_ISSUE) | (state == ST_SCALE_ISSUE);
  assign elem.elem_restart = idx == '0;
  assign elem.elem_mul_beta = state == ST_SCALE_ISSUE;
  assign elem.elem_w_val = w_vals[idx];
  assign elem.elem_z_val = z_vals[idx];
  assign elem.elem_mul_beta_in[0] = elem.elem_beta;
  assign elem.elem_mul_beta_in[1] = scale_val;
  // en_dly resets high so an en held through reset is not seen as a rising edge
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      en_dly     <= 1'b1;
      idx        <= '0;
      scale_en_q <= 1'b0;
      beta_out   <= '0;
    end else begin
      state      <= state_nx;
      en_dly     <= en;
      idx        <= idx_nx;
      scale_en_q <= scale_nx;
      beta_out   <= beta_nx;
    end
  end
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    scale_nx = scale_en_q;
    beta_nx  = beta_out;
    case (state)
      ST_IDLE: if (start) begin
        state_nx = ST_ISSUE;
        idx_nx   = '0;
        scale_nx = scale_en;
      end
      ST_ISSUE: state_nx = ST_GAP;
      ST_GAP:   state_nx = ST_WAIT;
      // a product of exactly 1 skips the scale step, mirroring the element's own multiply-by-1 skip
      ST_WAIT: if (elem.elem_ready) begin
        if (idx != LAST) begin
          idx_nx   = idx + 1'b1;
          state_nx = ST_ISSUE;
        end else if (scale_en_q && elem.elem_beta != FW'(1)) begin
          state_nx = ST_SCALE_ISSUE;
        end else begin
          beta_nx  = elem.elem_beta;
          state_nx = ST_DONE;
        end
      end
      ST_SCALE_ISSUE: state_nx = ST_SCALE_GAP;
      ST_SCALE_GAP:   state_nx = ST_SCALE_WAIT;
      ST_SCALE_WAIT: if (elem.elem_ready) begin
        beta_nx  = elem.elem_beta;
        state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_verifier_beta_sequencer.sv
// tb_verifier_beta_sequencer: directed runs against a behavioural beta element, scoreboard-checked on done
`ifndef F_NBITS
`define F_NBITS 61
`endif
module tb_verifier_beta_sequencer;
  localparam int N = 4;
  localparam int FW = `F_NBITS;
  typedef logic [FW-1:0] fe_t;
  typedef logic [N-1:0][FW-1:0] vec_t;
  typedef struct {
    fe_t  beta;
    int   npulse;
    logic mul;
  } exp_t;

  logic clk = 1'b0, rstb = 1'b0, en = 1'b1, scale_en = 1'b0;
  vec_t w_vals, z_vals;
  fe_t  scale_val = '0, beta_out;
  logic ready, done;
  verifier_beta_sequencer_if ei();

  verifier_beta_sequencer #(.NVALS(N)) dut (
    .clk(clk), .rstb(rstb), .en(en), .w_vals(w_vals), .z_vals(z_vals),
    .scale_en(scale_en), .scale_val(scale_val), .elem(ei),
    .ready(ready), .done(done), .beta_out(beta_out)
  );

  always #5 clk = ~clk;

  // behavioural element: busy for lat cycles after each request, product accumulates across non-restart requests
  int  lat = 3;
  int  cnt;
  logic busy;
  fe_t ebeta, res;
  function automatic fe_t factor(fe_t w, fe_t z);
    return 2 * w * z + 1 - w - z;
  endfunction
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      busy <= 1'b0; cnt <= 0; ebeta <= '0; res <= '0;
    end else if (ei.elem_en) begin
      busy <= 1'b1;
      cnt  <= lat;
      res  <= ei.elem_mul_beta ? fe_t'(ei.elem_mul_beta_in[0] * ei.elem_mul_beta_in[1]) :
              ei.elem_restart  ? factor(ei.elem_w_val, ei.elem_z_val) :
                                 fe_t'(ebeta * factor(ei.elem_w_val, ei.elem_z_val));
    end else if (busy) begin
      if (cnt <= 1) begin
        busy <= 1'b0; ebeta <= res;
      end else cnt <= cnt - 1;
    end
  end
  assign ei.elem_ready = ~busy;
  assign ei.elem_beta  = ebeta;

  exp_t exp_q[$];
  int   errors = 0, checks = 0, pulses = 0, restarts = 0, n_done = 0;
  logic first_rs = 1'b0, last_mul = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: count element requests and score each completed run against the queue
  always @(negedge clk) begin
    exp_t e;
    if (!rstb) begin
      pulses = 0; restarts = 0; first_rs = 1'b0; last_mul = 1'b0;
    end else begin
      if (ei.elem_en) begin
        if (pulses == 0) first_rs = ei.elem_restart;
        pulses++;
        restarts += int'(ei.elem_restart);
        last_mul = ei.elem_mul_beta;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with beta_out=%0d, expected no completion", beta_out);
        end else begin
          e = exp_q.pop_front();
          check("beta_out", beta_out, e.beta);
          check("pulse_count", pulses, e.npulse);
          check("restart_count", restarts, 1);
          check("first_restart", first_rs, 1);
          check("last_mul_beta", last_mul, e.mul);
        end
        n_done++;
        pulses = 0; restarts = 0;
      end
    end
  end

  function automatic vec_t v4(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = FW'(a); v[1] = FW'(b); v[2] = FW'(c); v[3] = FW'(d);
    return v;
  endfunction

  task automatic run(input vec_t w, input vec_t z, input logic se, input int sv, input int l,
                     input int eb, input int ep, input logic em, input bit repulse);
    int nd;
    @(negedge clk);
    w_vals = w; z_vals = z; scale_en = se; scale_val = FW'(sv); lat = l;
    exp_q.push_back('{FW'(eb), ep, em});
    nd = n_done;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    if (repulse) begin
      repeat (4) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
    end
    for (int c = 0; c < 300 && n_done == nd; c++) @(negedge clk);
    check("run_completed", n_done > nd, 1);
    repeat (3) @(negedge clk);
    check("ready_after_run", ready, 1);
  endtask

  initial begin
    w_vals = v4(1, 1, 1, 1);
    z_vals = v4(1, 1, 1, 1);
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_beta_out", beta_out, 0);
    check("reset_done", done, 0);
    check("reset_elem_en", ei.elem_en, 0);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    check("en_high_no_start", pulses, 0);
    check("en_high_ready", ready, 1);
    en = 1'b0;
    @(negedge clk);
    run(v4(1, 1, 1, 1), v4(1, 1, 1, 1), 1'b0, 0, 3, 1, 4, 1'b0, 1'b1);
    run(v4(1, 1, 1, 1), v4(1, 1, 1, 0), 1'b0, 0, 1, 0, 4, 1'b0, 1'b0);
    run(v4(2, 1, 1, 1), v4(3, 1, 1, 1), 1'b1, 5, 2, 40, 5, 1'b1, 1'b0);
    run(v4(1, 1, 1, 1), v4(1, 1, 1, 1), 1'b1, 7, 4, 1, 4, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("beta_out_hold", beta_out, 1);
    // abort a run while it waits on index 2
    scale_en = 1'b0; lat = 3;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 100 && pulses < 3; c++) @(negedge clk);
    check("reached_index2", pulses, 3);
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midreset_ready", ready, 1);
    check("midreset_beta_out", beta_out, 0);
    check("midreset_elem_en", ei.elem_en, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (8) @(negedge clk);
    check("after_reset_idle", pulses, 0);
    check("after_reset_ready", ready, 1);
    run(v4(2, 1, 1, 1), v4(3, 1, 1, 1), 1'b0, 9, 3, 8, 4, 1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
